// File: rtl/shift_pipe_unit.sv
// shift_pipe_unit: pipelined barrel shifter (SLL/SRL/SRA/ROR) with an elastic
// valid/ready pipeline. The log2(WIDTH) mux levels are distributed over
// PIPE_STAGES register stages; a destination tag rides along with each operation.
module shift_pipe_unit #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_W     = $clog2(WIDTH),
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 5
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   IN_DATA,
  input  logic [SHAMT_W-1:0] IN_SHAMT,
  input  logic [1:0]         IN_OP,
  input  logic [TAG_W-1:0]   IN_TAG,
  input  logic               FLUSH,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [WIDTH-1:0]   OUT_RESULT,
  output logic [TAG_W-1:0]   OUT_TAG
);

  localparam int LAST = PIPE_STAGES - 1;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One mux level: shift by 2^lvl. The SRA fill comes from the original
  // operand's sign bit, which is carried alongside the partially shifted data.
  function automatic logic [WIDTH-1:0] shift_level(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       op,
    input logic             sign,
    input int               lvl
  );
    int unsigned amt;
    logic [WIDTH-1:0] fill_mask;
    amt       = 32'd1 << lvl;
    fill_mask = ~({WIDTH{1'b1}} >> amt);
    case (op)
      OP_SLL:  shift_level = d << amt;
      OP_SRL:  shift_level = d >> amt;
      OP_SRA:  shift_level = (d >> amt) | (fill_mask & {WIDTH{sign}});
      default: shift_level = (d >> amt) | (d << (WIDTH - amt));
    endcase
  endfunction

  for (genvar gi = 0; gi < PIPE_STAGES; gi++) begin : g_stage
    // Stage inputs: the IN_* port for stage 0, the previous register otherwise.
    logic               src_valid;
    logic [WIDTH-1:0]   src_data;
    logic [SHAMT_W-1:0] src_shamt;
    logic [1:0]         src_op;
    logic               src_sign;
    logic [TAG_W-1:0]   src_tag;

    // Stage register and its next-state values.
    logic               adv;
    logic               valid_d;
    logic               load_en;
    logic [WIDTH-1:0]   data_d;
    logic               valid_q;
    logic [WIDTH-1:0]   data_q;
    logic [TAG_W-1:0]   tag_q;

    if (gi == 0) begin : g_src_in
      assign src_valid = IN_VALID && IN_READY;
      assign src_data  = IN_DATA;
      assign src_shamt = IN_SHAMT;
      assign src_op    = IN_OP;
      assign src_sign  = IN_DATA[WIDTH-1];
      assign src_tag   = IN_TAG;
    end else begin : g_src_prev
      assign src_valid = g_stage[gi-1].valid_q;
      assign src_data  = g_stage[gi-1].data_q;
      assign src_shamt = g_stage[gi-1].g_ctl.shamt_q;
      assign src_op    = g_stage[gi-1].g_ctl.op_q;
      assign src_sign  = g_stage[gi-1].g_ctl.sign_q;
      assign src_tag   = g_stage[gi-1].tag_q;
    end

    // A stage moves when it is empty or its successor (the consumer for the last) moves.
    if (gi == LAST) begin : g_adv_last
      assign adv = !valid_q || OUT_READY;
    end else begin : g_adv_mid
      assign adv = !valid_q || g_stage[gi+1].adv;
    end

    // Apply the mux levels that belong to this stage.
    always_comb begin
      data_d = src_data;
      for (int i = 0; i < SHAMT_W; i++) begin
        if (((i * PIPE_STAGES) / SHAMT_W) == gi && src_shamt[i]) begin
          data_d = shift_level(data_d, src_op, src_sign, i);
        end
      end
    end

    // Next valid and payload load enable; FLUSH empties every stage.
    always_comb begin
      valid_d = valid_q;
      load_en = 1'b0;
      if (FLUSH) begin
        valid_d = 1'b0;
      end else if (adv) begin
        valid_d = src_valid;
        load_en = src_valid;
      end
    end

    // Stage register: payload only loads when a real operation moves in.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        valid_q <= 1'b0;
        data_q  <= '0;
        tag_q   <= '0;
      end else begin
        valid_q <= valid_d;
        if (load_en) begin
          data_q <= data_d;
          tag_q  <= src_tag;
        end
      end
    end

    // Control fields are only needed by later stages, so the last stage drops them.
    if (gi < LAST) begin : g_ctl
      logic [SHAMT_W-1:0] shamt_q;
      logic [1:0]         op_q;
      logic               sign_q;

      // Carry shift amount, op and original sign bit to the next stage.
      always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
          shamt_q <= '0;
          op_q    <= '0;
          sign_q  <= 1'b0;
        end else if (load_en) begin
          shamt_q <= src_shamt;
          op_q    <= src_op;
          sign_q  <= src_sign;
        end
      end
    end
  end

  assign IN_READY   = g_stage[0].adv && !FLUSH && !RESET;
  assign OUT_VALID  = g_stage[LAST].valid_q;
  assign OUT_RESULT = g_stage[LAST].data_q;
  assign OUT_TAG    = g_stage[LAST].tag_q;

endmodule

// File: doc/shift_pipe_unit.md
Name: shift_pipe_unit

Overview:
- Parametrised, pipelined barrel shifter for the RV32IM execute stage. Successor to the combinational 32-bit SLL/SRL shifters.
- Supports logical left, logical right, arithmetic right and rotate right on a WIDTH-bit operand.
- Log2 mux levels are spread over PIPE_STAGES register stages. Each stage has a valid/ready elastic handshake and carries a destination tag for writeback.

Parameters:
- WIDTH, 32, operand/result width; power of two, minimum 8.
- SHAMT_W, $clog2(WIDTH), shift-amount width; number of mux levels.
- PIPE_STAGES, 2, register stages; legal range 1..SHAMT_W; equals latency in cycles.
- TAG_W, 5, width of the pass-through tag (destination register index).

Ports:
- CLK, input, 1, clock; all state changes on its rising edge.
- RESET, input, 1, asynchronous, active-high reset.
- IN_VALID, input, 1, input operation present.
- IN_READY, output, 1, unit can accept the input this cycle.
- IN_DATA, input, WIDTH, operand to shift.
- IN_SHAMT, input, SHAMT_W, shift amount; only these bits are used (RV32 semantics).
- IN_OP, input, 2, operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR.
- IN_TAG, input, TAG_W, passed through unchanged.
- FLUSH, input, 1, synchronous kill of all in-flight operations.
- OUT_VALID, output, 1, result available.
- OUT_READY, input, 1, consumer accepts the result.
- OUT_RESULT, output, WIDTH, shifted result.
- OUT_TAG, output, TAG_W, tag of the result.

Behaviour:
- Reset: one clock CLK; RESET is asynchronous and active-high.
  - While RESET is high: all stage valid bits = 0, OUT_VALID = 0, OUT_RESULT = 0, OUT_TAG = 0, IN_READY = 0.
  - After RESET deasserts: IN_READY = 1. In-flight operations are dropped immediately, including when reset is asserted mid-stream.
- Mux levels: level i shifts by 2^i and is controlled by IN_SHAMT[i].
  - Level i sits in stage floor(i*PIPE_STAGES/SHAMT_W).
  - Each stage ends in a register holding: data, remaining shamt bits, op, tag, valid.
  - Stage 0 registers sample the IN_* signals after the stage-0 levels.
  - The last stage register drives OUT_*.
- Fill rules:
  - SLL fills vacated LSBs with 0.
  - SRL fills vacated MSBs with 0.
  - SRA fills vacated MSBs with the original IN_DATA[WIDTH-1], which is carried through the stages.
  - ROR wraps the bits shifted out at the LSB into the MSBs.
- Shift amount 0: result equals IN_DATA for every op.
- Latency: exactly PIPE_STAGES cycles from acceptance (IN_VALID && IN_READY at edge N) to OUT_VALID at edge N+PIPE_STAGES, provided there is no stall.
- Throughput: 1 operation per cycle.
- Handshake, stage k (elastic pipeline):
  - Stage k advances when it is empty or stage k+1 advances.
  - The last stage advances when !OUT_VALID or OUT_READY.
  - IN_READY = stage-0 advance && !FLUSH && !RESET.
  - IN_READY is combinational from OUT_READY; no combinational path exists from IN_VALID to IN_READY.
- Stall: while OUT_VALID && !OUT_READY:
  - OUT_RESULT and OUT_TAG hold stable.
  - Internal bubbles still collapse.
  - No operation is lost, duplicated or reordered.
- FLUSH:
  - On the next edge, all stage valids clear; OUT_VALID drops the cycle after FLUSH is sampled.
  - FLUSH has priority over a simultaneous input; that input is not accepted because IN_READY is low.
  - Data registers need not clear.
- Simultaneous output accept and input accept in a full pipeline: both occur and occupancy stays constant.
- Data registers load only when the stage advances with valid data, to limit toggling.
- PIPE_STAGES=1: all levels are combinational ahead of a single output register.

Test Plan:
- SLL 0x00000001, shamt 31, tag 7 -> after PIPE_STAGES cycles OUT_RESULT=0x80000000, OUT_TAG=7.
- SRA 0x80000000, shamt 4 -> 0xF8000000. SRL same operand -> 0x08000000. SRA 0x7FFFFFF0, shamt 4 -> 0x07FFFFFF.
- ROR 0x12345678, shamt 8 -> 0x78123456. Any op with shamt 0 on 0xDEADBEEF -> 0xDEADBEEF.
- 8 back-to-back SLL ops (data = index, shamt = index, tag = index); OUT_READY low for 3 cycles after the second result -> 8 results in order with correct values/tags; OUT_RESULT stable during stall; IN_READY low only when all stages are full.
- 2 ops in flight, FLUSH pulsed for 1 cycle together with a third IN_VALID -> third op not accepted, no results emerge; a new op after FLUSH returns with normal latency.
- RESET asserted asynchronously between clock edges mid-stream -> OUT_VALID, OUT_RESULT and OUT_TAG go to 0 before the next edge; after release, the first op completes correctly.
- Repeat all scenarios for PIPE_STAGES = 1, 2, 5 and for WIDTH = 64 (SHAMT_W = 6).
